// File: rtl/score_update_scheduler.sv
// Round-robin scheduler that adds 0..3 points from four requesters into a saturating 3-digit BCD score.
// Define SCORE_FIFO_EN to queue granted requests; the default build uses a single holding slot.
module score_update_scheduler #(
    parameter int CAP_HUNDREDS = 9,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] req,
    input  logic [7:0] pts,
    output logic [3:0] ack,
    output logic [3:0] bcd_2,
    output logic [3:0] bcd_1,
    output logic [3:0] bcd_0,
    output logic       busy,
    output logic       sat,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ONES = 2'd1, TENS = 2'd2, HUND = 2'd3} state_t;

    localparam logic [3:0] CAP_DIGIT = 4'(CAP_HUNDREDS);

    if (CAP_HUNDREDS < 1 || CAP_HUNDREDS > 9) begin : g_bad_cap
        $error("CAP_HUNDREDS must be 1..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    // Valid/ready: req[i] is valid, ack[i] is the one-cycle ready pulse; req[i]/pts are held until ack[i] is seen.
    state_t     state, state_n;
    logic [3:0] d0, d1, d2, d0_n, d1_n, d2_n, sum;
    logic       carry, carry_n, sat_n;
    logic [1:0] op, op_n, rr_ptr, gnt_idx, scan_idx, gnt_pts, start_pts;
    logic [3:0] cand;
    logic       gnt_any, grant, slot_free, start, pending;

    assign cand = req & ~ack;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!gnt_any && cand[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign grant   = en && !clr && slot_free && gnt_any;
    assign gnt_pts = pts[{gnt_idx, 1'b0} +: 2];

`ifdef SCORE_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]    q_mem [FIFO_DEPTH];
    logic [AW-1:0] q_wr, q_rd;
    logic [AW:0]   q_cnt;
    logic          q_empty, q_full, pop, push, bypass;

    assign q_empty   = (q_cnt == '0);
    assign q_full    = (q_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop       = (state == IDLE) && !q_empty;
    assign bypass    = grant && (state == IDLE) && q_empty;
    assign push      = grant && !bypass;
    assign slot_free = !q_full;
    assign pending   = !q_empty;
    assign start     = pop || bypass;
    assign start_pts = pop ? q_mem[q_rd] : gnt_pts;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push) begin
                q_mem[q_wr] <= gnt_pts;
                q_wr        <= q_wr + 1'b1;
            end
            if (pop) q_rd <= q_rd + 1'b1;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end
`else
    // The operand register is the holding slot; it is free only while the adder is idle.
    assign slot_free = (state == IDLE);
    assign pending   = 1'b0;
    assign start     = grant;
    assign start_pts = gnt_pts;
`endif

    always_comb begin
        state_n = state;
        d0_n    = d0;
        d1_n    = d1;
        d2_n    = d2;
        carry_n = carry;
        op_n    = op;
        sat_n   = sat;
        sum     = 4'd0;
        if (clr) begin
            state_n = IDLE;
            d0_n    = 4'd0;
            d1_n    = 4'd0;
            d2_n    = 4'd0;
            carry_n = 1'b0;
            sat_n   = 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n = ONES;
                    op_n    = start_pts;
                end
                ONES: begin
                    sum     = d0 + {2'b00, op};
                    carry_n = (sum > 4'd9);
                    d0_n    = (sum > 4'd9) ? sum - 4'd10 : sum;
                    state_n = TENS;
                end
                TENS: begin
                    sum     = d1 + {3'b000, carry};
                    carry_n = (sum > 4'd9);
                    d1_n    = (sum > 4'd9) ? sum - 4'd10 : sum;
                    state_n = HUND;
                end
                HUND: begin
                    sum = d2 + {3'b000, carry};
                    if (sum > CAP_DIGIT) begin
                        d2_n  = CAP_DIGIT;
                        d1_n  = 4'd9;
                        d0_n  = 4'd9;
                        sat_n = 1'b1;
                    end else begin
                        d2_n = sum;
                    end
                    carry_n = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            d0     <= 4'd0;
            d1     <= 4'd0;
            d2     <= 4'd0;
            carry  <= 1'b0;
            op     <= 2'd0;
            sat    <= 1'b0;
            ack    <= 4'd0;
            rr_ptr <= 2'd0;
        end else begin
            state  <= state_n;
            d0     <= d0_n;
            d1     <= d1_n;
            d2     <= d2_n;
            carry  <= carry_n;
            op     <= op_n;
            sat    <= sat_n;
            ack    <= grant ? (4'b0001 << gnt_idx) : 4'd0;
            if (clr)        rr_ptr <= 2'd0;
            else if (grant) rr_ptr <= gnt_idx + 2'd1;
        end
    end

    assign bcd_0     = d0;
    assign bcd_1     = d1;
    assign bcd_2     = d2;
    assign busy      = (state != IDLE) || pending;
    assign dbg_state = state;

endmodule

// File: tb/tb_score_update_scheduler.sv
// Directed bench for score_update_scheduler in its default build (single holding slot, CAP_HUNDREDS=9).
module tb_score_update_scheduler;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       en;
  logic [3:0] req;
  logic [7:0] pts;
  logic [3:0] ack;
  logic [3:0] bcd_2, bcd_1, bcd_0;
  logic       busy;
  logic       sat;
  logic [1:0] dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  score_update_scheduler #(.CAP_HUNDREDS(9), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .req(req), .pts(pts),
    .ack(ack), .bcd_2(bcd_2), .bcd_1(bcd_1), .bcd_0(bcd_0),
    .busy(busy), .sat(sat), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] score();
    return {bcd_2, bcd_1, bcd_0};
  endfunction

  task automatic do_add(input int i, input logic [1:0] p);
    req = 4'(1) << i;
    pts = {4{p}};
    tick();
    chk("add_ack", {8'h0, ack}, {8'h0, 4'(1) << i});
    req = 4'd0;
    repeat (3) tick();
    chk("add_done_busy", {11'h0, busy}, 12'h0);
  endtask

  initial begin
    int waited;
    rst = 1'b1; clr = 1'b0; en = 1'b1; req = 4'd0; pts = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_score", score(), 12'h000);
    chk("reset_ack", {8'h0, ack}, 12'h0);
    chk("reset_busy", {11'h0, busy}, 12'h0);
    chk("reset_sat", {11'h0, sat}, 12'h0);
    chk("reset_state", {10'h0, dbg_state}, 12'h0);

    // First grant: ack next cycle, ONES after the grant edge, score after three more edges
    req = 4'b0001; pts = 8'h02;
    tick();
    chk("first_ack", {8'h0, ack}, 12'h001);
    chk("first_busy", {11'h0, busy}, 12'h1);
    chk("first_state_ones", {10'h0, dbg_state}, 12'h1);
    req = 4'd0;
    tick();
    chk("ack_one_cycle", {8'h0, ack}, 12'h0);
    repeat (2) tick();
    chk("first_score", score(), 12'h002);
    chk("first_idle", {10'h0, dbg_state}, 12'h0);

    // 002 + 32*3 = 098, then +3 carries through tens and hundreds
    for (int k = 0; k < 32; k++) do_add(k % 4, 2'd3);
    chk("score_098", score(), 12'h098);
    do_add(1, 2'd3);
    chk("score_101", score(), 12'h101);
    chk("sat_101", {11'h0, sat}, 12'h0);

    // 101 + 299*3 = 998, then saturation at 999 and sticky sat
    for (int k = 0; k < 299; k++) do_add(k % 4, 2'd3);
    chk("score_998", score(), 12'h998);
    chk("sat_998", {11'h0, sat}, 12'h0);
    do_add(0, 2'd3);
    chk("score_sat_999", score(), 12'h999);
    chk("sat_set", {11'h0, sat}, 12'h1);
    do_add(3, 2'd0);
    chk("score_999_add0", score(), 12'h999);
    chk("sat_sticky", {11'h0, sat}, 12'h1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_score", score(), 12'h000);
    chk("clr_sat", {11'h0, sat}, 12'h0);

    // All four requesting: order 0,1,2,3,0 with grants 4 cycles apart
    req = 4'b1111; pts = 8'h55;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (ack == 4'd0 && waited < 8);
      chk("rr_order", {8'h0, ack}, {8'h0, 4'(1) << (k % 4)});
      chk("rr_spacing", 12'(waited), (k == 0) ? 12'd1 : 12'd4);
    end
    req = 4'd0;
    repeat (3) tick();
    chk("rr_score_005", score(), 12'h005);

    // clr returns the round-robin pointer to requester 0
    do_add(2, 2'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req = 4'b1111; pts = 8'h00;
    tick();
    chk("rr_after_clr", {8'h0, ack}, 12'h001);
    req = 4'd0;
    repeat (3) tick();

    // clr in TENS of 009 + 3
    for (int k = 0; k < 3; k++) do_add(0, 2'd3);
    chk("score_009", score(), 12'h009);
    req = 4'b0001; pts = 8'h03;
    tick();
    req = 4'd0;
    tick();
    chk("state_tens", {10'h0, dbg_state}, 12'h2);
    clr = 1'b1;
    tick();
    chk("clr_tens_score", score(), 12'h000);
    chk("clr_tens_ack", {8'h0, ack}, 12'h0);
    chk("clr_tens_busy", {11'h0, busy}, 12'h0);

    // clr also blocks a grant in its cycle
    req = 4'b0010; pts = 8'h04;
    tick();
    chk("clr_no_ack", {8'h0, ack}, 12'h0);
    chk("clr_no_busy", {11'h0, busy}, 12'h0);
    clr = 1'b0;
    tick();
    chk("post_clr_ack", {8'h0, ack}, 12'h002);
    req = 4'd0;
    repeat (3) tick();
    chk("score_001", score(), 12'h001);

    // en=0 blocks new grants but not an in-flight add
    en = 1'b0; req = 4'b0001; pts = 8'h02;
    repeat (2) tick();
    chk("en0_no_ack", {8'h0, ack}, 12'h0);
    chk("en0_no_busy", {11'h0, busy}, 12'h0);
    en = 1'b1;
    tick();
    chk("en1_ack", {8'h0, ack}, 12'h001);
    req = 4'd0; en = 1'b0;
    repeat (3) tick();
    chk("en0_inflight_done", score(), 12'h003);
    en = 1'b1;

    // rst mid-add
    req = 4'b0001; pts = 8'h02;
    tick();
    req = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_score", score(), 12'h000);
    chk("rst_mid_busy", {11'h0, busy}, 12'h0);
    chk("rst_mid_state", {10'h0, dbg_state}, 12'h0);
    tick();
    chk("rst_mid_ack", {8'h0, ack}, 12'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
